uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive path for the direct serial pin (rxd) on the thinpad board, feeding the CPU's serial-port MMIO reads. Samples rxd at 16x oversampling and decodes 8N1 frames, LSB first. Accepted bytes go into a first-word-fall-through FIFO that the CPU pops. Sticky error flags report framing errors and overruns.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate
FIFO_DEPTH, 16, receive FIFO entries (power of two, ≥2)
DIV, round(CLK_FREQ/(BAUD*16)), derived localparam: clocks per oversample tick (27 at defaults)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
rxd  in  1  asynchronous serial input, idle high
rd_en  in  1  pop request for FIFO head
err_clr  in  1  clears frame_err and overrun_err
rd_data  out  8  FIFO head byte (FWFT), 0 when empty
rx_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored bytes
frame_err  out  1  sticky: stop bit sampled low
overrun_err  out  1  sticky: byte dropped because FIFO was full

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous and active-low. All state is updated on the rising edge of clk.
- Reset: rd_data=0, rx_valid=0, fifo_count=0, frame_err=0, overrun_err=0, FSM=IDLE, tick counter=0, synchroniser flops=1. Reset mid-frame discards the partial byte.
- Input path: 2-flop synchroniser followed by one history flop for edge detection.
- Tick generator: counter 0..DIV-1; emits a one-cycle tick at DIV-1. It free-runs in IDLE and is restarted at the detected falling edge.
- Sample counter: 0..15 per bit. Bit value = majority of the synced rxd at sample counts 7, 8 and 9, decided at count 9.
- FSM:
  - IDLE: on falling edge of synced rxd → START, with tick and sample counters cleared.
  - START: at the decision point, majority 1 → IDLE (glitch rejected, nothing reported). Majority 0 → DATA at the end of bit (sample 15), bit index 0.
  - DATA: 8 bits shifted in LSB first; after bit 7 → STOP.
  - STOP: at the decision point, majority 1 → push byte. Majority 0 → set frame_err and discard byte. Either way → IDLE immediately (mid stop bit).
  - IDLE requires a new falling edge, so a held-low break line does not retrigger.
- Push: occurs in the same cycle as the STOP decision. rx_valid and rd_data reflect the new byte on the next cycle when the FIFO was empty.
- FIFO:
  - Circular buffer with read and write pointers plus count; rd_data is driven combinationally from the head entry.
  - Pop when rd_en && rx_valid; rd_en while empty is ignored.
  - Push when full without pop → byte dropped, overrun_err set, count stays FIFO_DEPTH.
  - Push and pop in the same cycle at full → both performed, count unchanged, no overrun.
  - Push and pop in the same cycle when empty → push only.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags: sticky until err_clr. If a set event and err_clr occur in the same cycle, set wins.

Decomposition:
- Package uart_pkg holds:
  - OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9
  - rx state enum {IDLE, START, DATA, STOP}
  - function computing DIV from CLK_FREQ and BAUD
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, FWFT read). It is reused later for the TX path.

Test Plan:
1. Frame 0x55 at 115200 baud (bit period 432 clk) → about 4104 clk after the start edge, rx_valid=1, rd_data=0x55, fifo_count=1. rd_en one cycle → rx_valid=0, fifo_count=0, rd_data=0.
2. rxd low for 100 clk, then high → FSM returns to IDLE, no push, rx_valid=0, frame_err=0. A following 0xA7 frame is received correctly.
3. Frame 0xA3 with stop bit driven 0 → frame_err=1, fifo_count=0. Pulse err_clr → frame_err=0. Then err_clr held high while another bad stop bit arrives → frame_err=1 (set wins).
4. 17 frames 0x00..0x10 with no pops → fifo_count=16, overrun_err=1. 16 pops return 0x00..0x0F in order, then rx_valid=0.
5. FIFO full (16 entries); rd_en asserted exactly in the push cycle of byte 0x99 → fifo_count stays 16, overrun_err=0, 0x99 is the last byte popped.
6. rst_n=0 for 1 cycle during data bit 4 → all outputs at reset values next cycle. A subsequent 0x3C frame → rd_data=0x3C, fifo_count=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding
// and baud divider helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] SAMPLE_END = 4'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with first-word-fall-through read.
// A push into a full FIFO is only taken when a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt_q;
  assign rdata   = empty ? '0 : mem_q[rd_q];

  // Pointer and occupancy update; pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents are masked by empty on read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampled 8N1 receiver feeding a FWFT byte FIFO,
// with sticky framing and overrun error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rxd,
  input  logic                        rd_en,
  input  logic                        err_clr,
  output logic [7:0]                  rd_data,
  output logic                        rx_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  logic s1_q, s1_d, s2_q, s2_d, hist_q, hist_d;
  logic rx_s, fall;

  rx_state_e     state_q;
  logic [TW-1:0] tick_q;
  logic [3:0]    samp_q;
  logic [2:0]    bit_q;
  logic          v_lo_q, v_mid_q;
  logic [7:0]    shreg_q;

  logic tick, maj, decide, last;
  logic push, ferr_set, ovr_set;
  logic full, empty;

  logic frame_err_q, frame_err_d;
  logic overrun_err_q, overrun_err_d;

  // Synchroniser chain plus history for edge detect.
  always_comb begin
    s1_d   = rxd;
    s2_d   = s1_q;
    hist_d = s2_q;
  end

  // Synchroniser registers idle high out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign rx_s   = s2_q;
  assign fall   = hist_q && !rx_s;
  assign tick   = (tick_q == TICK_MAX);
  assign maj    = (v_lo_q & v_mid_q) | (v_lo_q & rx_s) | (v_mid_q & rx_s);
  assign decide = tick && (samp_q == SAMPLE_HI);
  assign last   = tick && (samp_q == SAMPLE_END);

  assign push     = (state_q == STOP) && decide && maj;
  assign ferr_set = (state_q == STOP) && decide && !maj;
  assign ovr_set  = push && full && !rd_en;

  // Frame FSM with tick, sample and bit counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      v_lo_q  <= 1'b1;
      v_mid_q <= 1'b1;
      shreg_q <= '0;
    end else begin
      tick_q <= tick ? '0 : tick_q + 1'b1;
      if (tick) begin
        samp_q <= samp_q + 1'b1;
        if (samp_q == SAMPLE_LO)  v_lo_q  <= rx_s;
        if (samp_q == SAMPLE_MID) v_mid_q <= rx_s;
      end
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            tick_q  <= '0;
            samp_q  <= '0;
          end
        end
        START: begin
          if (decide && maj) begin
            state_q <= IDLE;
          end else if (last) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (decide) shreg_q <= {maj, shreg_q[7:1]};
          if (last) begin
            if (bit_q == 3'd7) state_q <= STOP;
            else bit_q <= bit_q + 1'b1;
          end
        end
        STOP: begin
          if (decide) state_q <= IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a new error beats a simultaneous clear.
  always_comb begin
    frame_err_d   = ferr_set || (frame_err_q && !err_clr);
    overrun_err_d = ovr_set || (overrun_err_q && !err_clr);
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (rd_en),
    .wdata(shreg_q),
    .rdata(rd_data),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );

  assign rx_valid    = !empty;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule
